ex_multu_unit: RTL and testbench
================================

Name: ex_multu_unit

Overview:
- Execute-stage multiply unit that consumes the ID/EX pipeline register outputs (multu_enE, alu_paE, wd_dmE).
- Performs an iterative unsigned 32x32 -> 64 multiply, one bit per cycle, and owns the HI/LO architectural registers.
- Raises a stall to the hazard logic while a multiply is in flight.
- HI_q/LO_q feed back to the decode stage as HI_qD/LO_qD for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  synchronous active-low reset
- multu_en  input  1  start request from ID/EX register (multu_enE)
- flush  input  1  squash in-flight multiply (branch/jump redirect)
- op_a  input  WIDTH  multiplicand (rs value, alu_paE)
- op_b  input  WIDTH  multiplier (rt value, wd_dmE)
- we_hi  input  1  mthi write enable
- we_lo  input  1  mtlo write enable
- wd_hilo  input  WIDTH  mthi/mtlo write data
- busy  output  1  stall request; high whenever state != IDLE
- done  output  1  one-cycle pulse, HI/LO just updated by a multiply
- HI_q  output  WIDTH  HI register
- LO_q  output  WIDTH  LO register

Behaviour:
- Reset: rst_n=0 at a rising edge forces state=IDLE, cnt=0, product reg P=0, HI_q=0, LO_q=0, done=0, busy=0. Reset overrides all other inputs, including mid-multiply; a partial result is discarded.
- State register: 2-bit, states IDLE, RUN, DONE.
- IDLE:
  - multu_en=1 and flush=0 at an edge: P <= {(WIDTH+1)'b0, op_b}, A <= op_a, cnt <= 0, go to RUN.
  - flush=1 in IDLE suppresses the start.
- RUN, one iteration per cycle:
  - If P[0], upper = P[2W:W] + {1'b0, A}, 33-bit with carry, else upper unchanged.
  - P <= {upper, P[W-1:0]} >> 1.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge: HI_q <= final P[2W-1:W], LO_q <= final P[W-1:0], go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE: done=1 for exactly this cycle and busy=1. Next edge goes to IDLE unconditionally; a multu_en in the DONE cycle is ignored, because the pipeline is still stalled.
- Latency: start edge at cycle 0, HI/LO valid and done high at cycle WIDTH+1 (33), busy low at cycle 34.
- Flush in RUN: next edge goes to IDLE. HI/LO are unchanged and no done pulse is produced. Flush in DONE has no effect, since HI/LO are already committed.
- multu_en while RUN/DONE is ignored; no queueing.
- mthi/mtlo:
  - Honoured only when state==IDLE. HI_q <= wd_hilo if we_hi; LO_q <= wd_hilo if we_lo; both may assert together.
  - Ignored while busy.
  - If we_hi/we_lo and multu_en are both asserted in IDLE, the write lands now and the multiply later overwrites both registers.
- busy is combinational from the state register only; it has no combinational path from inputs.
- Arithmetic is strictly unsigned. The carry bit P[2W] is required, and dropping it fails the all-ones case.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - MULT_LATENCY = WIDTH+1 for the hazard unit and the bench.
- One natural sub-module, hilo_regs: the HI/LO register pair with write enables, shared by the multiply commit path and mthi/mtlo.
- The FSM, counter and shift-add datapath stay in ex_multu_unit.

Test Plan:
- Basic multiply: reset, then multu_en with op_a=3, op_b=5 -> busy high for 33 cycles; done pulse at cycle 33; HI_q=0x00000000, LO_q=0x0000000F.
- Carry case: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> HI_q=0xFFFFFFFE, LO_q=0x00000001.
- Ignored start and mthi while busy: start 0x10000*0x10000 (HI=1, LO=0); re-assert multu_en with 7*7 and we_hi with 0xDEAD at cycle 10 -> final HI_q=0x00000001, LO_q=0; exactly one done pulse.
- Flush: preload HI=0xAAAA via mthi and LO=0x5555 via mtlo; start 9*9, assert flush at cycle 20 -> busy low at cycle 21; HI/LO still 0xAAAA/0x5555; no done pulse.
- Reset mid-operation: rst_n=0 at cycle 15 of a run -> next edge HI_q=LO_q=0, busy=0; a fresh 6*7 afterwards gives LO_q=42.
- Direct writes: we_hi=we_lo=1 with wd_hilo=0x12345678 in IDLE -> both registers read 0x12345678 on the next cycle; done stays 0.

Source files
------------

// File: rtl/ex_multu_unit_pkg.sv
// ex_multu_unit_pkg
// Shared definitions for the execute-stage unsigned multiply unit.
//   mult_state_t : FSM state encoding (IDLE, RUN, DONE)
//   MULT_WIDTH   : default operand width
//   MULT_LATENCY : cycles from the start edge until HI/LO hold the product,
//                  used by the hazard unit to size its stall window
package ex_multu_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH   = 32;
    localparam int MULT_LATENCY = MULT_WIDTH + 1;

endpackage

// File: rtl/ex_multu_unit_hilo_regs.sv
// hilo_regs
// HI/LO architectural register pair. It is shared by the multiply commit
// path and by mthi/mtlo. The two registers have independent write enables
// and write data.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   we_hi/wd_hi: HI write enable / data
//   we_lo/wd_lo: LO write enable / data
//   hi, lo     : current register contents
module hilo_regs
    import ex_multu_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_hi,
    input  logic [WIDTH-1:0] wd_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (we_hi) hi <= wd_hi;
            if (we_lo) lo <= wd_lo;
        end
    end

endmodule

// File: rtl/ex_multu_unit.sv
// ex_multu_unit
// Execute-stage iterative unsigned multiplier (WIDTH x WIDTH -> 2*WIDTH).
// It retires one multiplier bit per cycle and owns the HI/LO registers.
// Ports:
//   clk, rst_n     : rising-edge clock, synchronous active-low reset
//   multu_en       : start request (ID/EX multu_enE)
//   flush          : squash an in-flight multiply
//   op_a, op_b     : multiplicand / multiplier
//   we_hi, we_lo   : mthi / mtlo enables (honoured only when idle)
//   wd_hilo        : mthi / mtlo write data
//   busy           : stall request, high whenever the FSM is not idle
//   done           : one-cycle pulse, HI/LO were just updated by a multiply
//   HI_q, LO_q     : HI / LO register outputs
module ex_multu_unit
    import ex_multu_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             multu_en,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd_hilo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI_q,
    output logic [WIDTH-1:0] LO_q
);

    mult_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [2*WIDTH:0]  p_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH:0]    upper;
    logic [2*WIDTH:0]  p_next;
    logic              last_iter;
    logic              commit;
    logic              idle_write;
    logic              hi_we;
    logic              lo_we;
    logic [WIDTH-1:0]  hi_wd;
    logic [WIDTH-1:0]  lo_wd;

    // Shift-add step. The upper half keeps one extra carry bit. Without it,
    // the sum would overflow when both operands are all ones.
    always_comb begin
        upper = p_reg[2*WIDTH:WIDTH];
        if (p_reg[0]) begin
            upper = p_reg[2*WIDTH:WIDTH] + {1'b0, a_reg};
        end
        p_next = {upper, p_reg[WIDTH-1:0]} >> 1;
    end

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // A flush on the final iteration still wins, so nothing is committed.
    assign commit     = (state == RUN) && !flush && last_iter;
    assign idle_write = (state == IDLE);

    // The commit path and mthi/mtlo cannot collide. They are active in
    // different states.
    assign hi_we = commit || (idle_write && we_hi);
    assign lo_we = commit || (idle_write && we_lo);
    assign hi_wd = commit ? p_next[2*WIDTH-1:WIDTH] : wd_hilo;
    assign lo_wd = commit ? p_next[WIDTH-1:0]       : wd_hilo;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            p_reg <= '0;
            a_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (multu_en && !flush) begin
                        p_reg <= {{(WIDTH+1){1'b0}}, op_b};
                        a_reg <= op_a;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        p_reg <= p_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_iter) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    hilo_regs #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk   (clk),
        .rst_n (rst_n),
        .we_hi (hi_we),
        .wd_hi (hi_wd),
        .we_lo (lo_we),
        .wd_lo (lo_wd),
        .hi    (HI_q),
        .lo    (LO_q)
    );

endmodule

// File: tb/tb_ex_multu_unit.sv
// tb_ex_multu_unit
// Directed testbench for ex_multu_unit. Each scenario uses hand-computed
// products. The cycle numbering counts the start edge as cycle 0, so
// cycle k is the period after k clock edges.
module tb_ex_multu_unit;
    import ex_multu_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        multu_en;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd_hilo;
    logic        busy;
    logic        done;
    logic [31:0] HI_q;
    logic [31:0] LO_q;

    int checks   = 0;
    int failures = 0;

    int busy_cnt;
    int busy_end;
    int done_cnt;
    int done_at;

    ex_multu_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .multu_en (multu_en),
        .flush    (flush),
        .op_a     (op_a),
        .op_b     (op_b),
        .we_hi    (we_hi),
        .we_lo    (we_lo),
        .wd_hilo  (wd_hilo),
        .busy     (busy),
        .done     (done),
        .HI_q     (HI_q),
        .LO_q     (LO_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start a multiply, then observe 40 cycles. Optional one-cycle
    // disturbances can be placed at given cycles: a 7*7 start together with
    // mthi 0xDEAD, a flush, or a reset. A value of 0 disables a disturbance.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input int inj_cyc, input int flush_cyc,
                                  input int rst_cyc);
        multu_en = 1'b1;
        op_a     = a;
        op_b     = b;
        tick();
        multu_en = 1'b0;
        busy_cnt = 0;
        busy_end = -1;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_cnt++;
            else if (busy_end < 0) busy_end = c;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (c == inj_cyc) begin
                multu_en = 1'b1;
                op_a     = 32'd7;
                op_b     = 32'd7;
                we_hi    = 1'b1;
                wd_hilo  = 32'h0000DEAD;
            end
            if (c == flush_cyc) flush = 1'b1;
            if (c == rst_cyc) rst_n = 1'b0;
            tick();
            multu_en = 1'b0;
            we_hi    = 1'b0;
            flush    = 1'b0;
            rst_n    = 1'b1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        multu_en = 1'b0;
        flush    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        we_hi    = 1'b0;
        we_lo    = 1'b0;
        wd_hilo  = '0;

        // Reset state
        tick();
        tick();
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_hi", 64'(HI_q), 64'd0);
        check_output("reset_lo", 64'(LO_q), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic multiply 3*5
        $display("[TB] basic multiply");
        apply_stimulus(32'd3, 32'd5, 0, 0, 0);
        check_output("basic_busy_cycles", 64'(busy_cnt), 64'd33);
        check_output("basic_busy_end", 64'(busy_end), 64'd34);
        check_output("basic_done_cnt", 64'(done_cnt), 64'd1);
        check_output("basic_done_at", 64'(done_at), 64'(MULT_LATENCY));
        check_output("basic_hi", 64'(HI_q), 64'h0);
        check_output("basic_lo", 64'(LO_q), 64'hF);

        // Carry case: all ones squared
        $display("[TB] carry case");
        apply_stimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        check_output("carry_done_at", 64'(done_at), 64'd33);
        check_output("carry_hi", 64'(HI_q), 64'hFFFFFFFE);
        check_output("carry_lo", 64'(LO_q), 64'h00000001);

        // A start and an mthi while busy are both ignored
        $display("[TB] ignored start and mthi");
        apply_stimulus(32'h00010000, 32'h00010000, 10, 0, 0);
        check_output("ign_done_cnt", 64'(done_cnt), 64'd1);
        check_output("ign_busy_cycles", 64'(busy_cnt), 64'd33);
        check_output("ign_hi", 64'(HI_q), 64'h1);
        check_output("ign_lo", 64'(LO_q), 64'h0);

        // Flush mid-run; also an mthi attempt at cycle 5 that must be ignored
        $display("[TB] flush");
        we_hi   = 1'b1;
        wd_hilo = 32'h0000AAAA;
        tick();
        we_hi   = 1'b0;
        we_lo   = 1'b1;
        wd_hilo = 32'h00005555;
        tick();
        we_lo   = 1'b0;
        check_output("preload_hi", 64'(HI_q), 64'hAAAA);
        check_output("preload_lo", 64'(LO_q), 64'h5555);
        apply_stimulus(32'd9, 32'd9, 5, 20, 0);
        check_output("flush_busy_end", 64'(busy_end), 64'd21);
        check_output("flush_done_cnt", 64'(done_cnt), 64'd0);
        check_output("flush_hi", 64'(HI_q), 64'hAAAA);
        check_output("flush_lo", 64'(LO_q), 64'h5555);

        // Reset mid-operation clears HI/LO and drops busy on the next edge
        $display("[TB] reset mid-run");
        apply_stimulus(32'd9, 32'd9, 0, 0, 15);
        check_output("rst_busy_end", 64'(busy_end), 64'd16);
        check_output("rst_done_cnt", 64'(done_cnt), 64'd0);
        check_output("rst_hi", 64'(HI_q), 64'h0);
        check_output("rst_lo", 64'(LO_q), 64'h0);
        apply_stimulus(32'd6, 32'd7, 0, 0, 0);
        check_output("fresh_lo", 64'(LO_q), 64'd42);
        check_output("fresh_hi", 64'(HI_q), 64'd0);
        check_output("fresh_done_cnt", 64'(done_cnt), 64'd1);

        // Direct writes in IDLE
        $display("[TB] direct writes");
        we_hi   = 1'b1;
        we_lo   = 1'b1;
        wd_hilo = 32'h12345678;
        tick();
        we_hi   = 1'b0;
        we_lo   = 1'b0;
        check_output("mt_both_hi", 64'(HI_q), 64'h12345678);
        check_output("mt_both_lo", 64'(LO_q), 64'h12345678);
        check_output("mt_both_done", 64'(done), 64'd0);
        check_output("mt_both_busy", 64'(busy), 64'd0);
        we_hi   = 1'b1;
        wd_hilo = 32'hCAFEF00D;
        tick();
        we_hi   = 1'b0;
        check_output("mthi_only_hi", 64'(HI_q), 64'hCAFEF00D);
        check_output("mthi_only_lo", 64'(LO_q), 64'h12345678);

        // A write together with a start lands now, then the product overwrites both
        $display("[TB] write with start");
        we_hi    = 1'b1;
        we_lo    = 1'b1;
        wd_hilo  = 32'h00000077;
        multu_en = 1'b1;
        op_a     = 32'd2;
        op_b     = 32'd3;
        tick();
        we_hi    = 1'b0;
        we_lo    = 1'b0;
        multu_en = 1'b0;
        check_output("wstart_hi", 64'(HI_q), 64'h77);
        check_output("wstart_lo", 64'(LO_q), 64'h77);
        check_output("wstart_busy", 64'(busy), 64'd1);
        for (int c = 0; c < 40 && busy; c++) tick();
        check_output("wstart_idle", 64'(busy), 64'd0);
        check_output("wstart_final_hi", 64'(HI_q), 64'h0);
        check_output("wstart_final_lo", 64'(LO_q), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
